// File: rtl/serial_paralelo_rx_pkg.sv
// Shared symbols for the serial link: byte width, COM idle symbol, receiver FSM states.
package serial_paralelo_rx_pkg;

  localparam int unsigned BW            = 8;
  localparam logic [BW-1:0] COM         = 8'hBC;
  localparam int unsigned COM_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  function automatic logic is_com(input logic [BW-1:0] b);
    return b == COM;
  endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial receive link: one bit in, aligned payload byte + valid + link-active out.
interface serial_paralelo_rx_if;
  import serial_paralelo_rx_pkg::*;

  logic          data_in;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          active;

  // master: serial source / payload consumer; slave: the receiver
  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);

endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for COM, aligns after COM_COUNT aligned COMs, then
// delivers non-COM bytes on the edge that samples their LSB, held for one BW-cycle slot.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter int unsigned COM_COUNT = COM_COUNT_DEF
) (
  input  logic clk32f,
  input  logic reset,
  serial_paralelo_rx_if.slave link
);

  localparam logic [3:0] COM_TGT  = 4'(COM_COUNT);
  localparam logic [2:0] BIT_LAST = 3'(BW - 1);

  // Only the newest BW-1 bits are ever needed: next_byte appends the live input bit.
  logic [BW-2:0] sr_q, sr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    com_cnt_q, com_cnt_d;
  rx_state_e     state_q, state_d;
  logic [BW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          active_q, active_d;

  logic [BW-1:0] next_byte;
  logic          boundary;
  logic          next_is_com;

  assign next_byte   = {sr_q, link.data_in};
  assign next_is_com = is_com(next_byte);
  assign boundary    = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    sr_d      = next_byte[BW-2:0];

    unique case (state_q)
      SEARCH: begin
        if (next_is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          if (COM_TGT == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (next_is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == COM_TGT) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d   = SEARCH;
            com_cnt_d = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        // COM is idle fill: drop valid but keep the last payload byte on data_out
        if (boundary) begin
          if (next_is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = next_byte;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign link.data_out  = data_q;
  assign link.valid_out = valid_q;
  assign link.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: table-driven alignment/payload stream plus reset,
// broken-alignment and long payload sequences.
module tb_serial_paralelo_rx;

  logic clk32f = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  serial_paralelo_rx_if link ();

  serial_paralelo_rx dut (
    .clk32f (clk32f),
    .reset  (reset),
    .link   (link)
  );

  always #5 clk32f = ~clk32f;

  typedef struct {
    logic [7:0] byte_in;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_act;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] d, input logic a);
    chk({name, ".valid"},  {7'd0, link.valid_out}, {7'd0, v});
    chk({name, ".data"},   link.data_out, d);
    chk({name, ".active"}, {7'd0, link.active}, {7'd0, a});
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk32f);
    link.data_in = b;
    @(posedge clk32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    @(negedge clk32f);
    reset = 1'b1;
    @(negedge clk32f);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] prefix;
    logic       pv;
    logic [7:0] pd;
    logic       pa;

    reset        = 1'b1;
    link.data_in = 1'b0;

    tbl[0]  = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{8'hBC, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{8'h5A, 1'b1, 8'h5A, 1'b1};
    tbl[5]  = '{8'h12, 1'b1, 8'h12, 1'b1};
    tbl[6]  = '{8'hBC, 1'b0, 8'h12, 1'b1};
    tbl[7]  = '{8'h34, 1'b1, 8'h34, 1'b1};
    tbl[8]  = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[9]  = '{8'h00, 1'b1, 8'h00, 1'b1};
    tbl[10] = '{8'hBC, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{8'hBC, 1'b0, 8'h00, 1'b1};

    // reset held with random serial data: outputs stay cleared
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom));
      chk_out("reset_hold", 1'b0, 8'h00, 1'b0);
    end
    @(negedge clk32f);
    reset = 1'b0;

    // three-bit offset before the first COM; 110 forms no COM with the leading bits
    prefix = 3'b110;
    for (int i = 2; i >= 0; i--) send_bit(prefix[i]);

    pv = 1'b0; pd = 8'h00; pa = 1'b0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 7; i >= 4; i--) send_bit(tbl[k].byte_in[i]);
      chk_out($sformatf("tbl%0d_mid", k), pv, pd, pa);
      for (int i = 3; i >= 0; i--) send_bit(tbl[k].byte_in[i]);
      chk_out($sformatf("tbl%0d_end", k), tbl[k].exp_vld, tbl[k].exp_dat, tbl[k].exp_act);
      pv = tbl[k].exp_vld; pd = tbl[k].exp_dat; pa = tbl[k].exp_act;
    end

    // broken COM run returns to SEARCH; activation needs four fresh COMs
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_byte(8'h00);
    chk_out("broken_run", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      chk_out($sformatf("realign_com%0d", i + 1), 1'b0, 8'h00, 1'b0);
    end
    send_byte(8'hBC);
    chk_out("realign_com4", 1'b0, 8'h00, 1'b1);
    send_byte(8'h77);
    chk_out("realign_payload", 1'b1, 8'h77, 1'b1);

    // asynchronous reset mid-byte while active
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 8'h00, 1'b0);
    @(negedge clk32f);
    reset = 1'b0;
    send_byte(8'h5A);
    chk_out("post_reset_no_align", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk_out("post_reset_com3", 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC);
    chk_out("post_reset_com4", 1'b0, 8'h00, 1'b1);
    send_byte(8'h5A);
    chk_out("post_reset_payload", 1'b1, 8'h5A, 1'b1);

    // back-to-back payload stream 0x01..0xFF without COM
    for (int b = 1; b < 256; b++) begin
      if (b != 'hBC) begin
        send_byte(8'(b));
        chk($sformatf("stream_%02h.data", b), link.data_out, 8'(b));
        chk($sformatf("stream_%02h.valid", b), {7'd0, link.valid_out}, 8'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
